// File: rtl/store_align_unit.sv
// Buffered store path: queues execute-stage stores and presents lane-aligned write beats to DMEM/IMEM.
// Optional macro STORE_SPLIT_EN: split word-crossing stores into two beats (otherwise misaligned stores are dropped).
module store_align_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   st_valid,
    output logic                   st_ready,
    input  logic [2:0]             st_funct3,
    input  logic [ADDR_W-1:0]      st_addr,
    input  logic [DATA_W-1:0]      st_data,
    input  logic [1:0]             st_dst,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_din,
    output logic [DATA_W/8-1:0]    mem_wea,
    output logic [1:0]             mem_dst,
    output logic                   misalign_err,
    output logic [$clog2(DEPTH):0] pending
);

    localparam int WB    = DATA_W / 8;
    localparam int OFF_W = $clog2(WB);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SZ_W  = OFF_W + 2;   // wide enough for off + size without overflow

    typedef struct packed {
        logic [1:0]        size_code;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [1:0]        dst;
    } entry_t;

    function automatic logic [SZ_W-1:0] size_bytes(input logic [1:0] code);
        return SZ_W'(1) << code;
    endfunction

    function automatic logic [2*WB-1:0] lane_mask(input logic [1:0] code, input logic [OFF_W-1:0] off);
        logic [2*WB-1:0] ones;
        ones = ~({(2*WB){1'b1}} << size_bytes(code));
        return ones << off;
    endfunction

    function automatic logic is_legal(input logic [2:0] f3);
        return !f3[2] && (f3[1:0] != 2'b11 || DATA_W == 64);
    endfunction

    entry_t            queue [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              st_fire;
    logic              st_ok;
    logic              push;
    logic              pop;

    entry_t              head;
    logic [OFF_W-1:0]    head_off;
    logic [2*WB-1:0]     head_mask;
    logic [2*DATA_W-1:0] head_shifted;
    logic [ADDR_W-1:0]   head_base;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign st_ready = !full;
    assign pending  = count;
    assign st_fire  = st_valid && st_ready;

`ifdef STORE_SPLIT_EN
    function automatic logic is_crossing(input logic [1:0] code, input logic [OFF_W-1:0] off);
        return (SZ_W'(off) + size_bytes(code)) > SZ_W'(WB);
    endfunction

    assign st_ok = is_legal(st_funct3);
`else
    function automatic logic is_misaligned(input logic [1:0] code, input logic [OFF_W-1:0] off);
        logic [SZ_W-1:0] low_bits;
        low_bits = size_bytes(code) - SZ_W'(1);
        return (SZ_W'(off) & low_bits) != '0;
    endfunction

    assign st_ok = is_legal(st_funct3) && !is_misaligned(st_funct3[1:0], st_addr[OFF_W-1:0]);
`endif

    assign push = st_fire && st_ok;

    // Head decode: the double-width shift holds both beats of a crossing store.
    assign head         = queue[rd_ptr];
    assign head_off     = head.addr[OFF_W-1:0];
    assign head_mask    = lane_mask(head.size_code, head_off);
    assign head_shifted = {{DATA_W{1'b0}}, head.data} << {head_off, 3'b000};
    assign head_base    = {head.addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

`ifdef STORE_SPLIT_EN
    typedef enum logic {BEAT0, BEAT1} beat_t;

    beat_t state;
    logic  head_crossing;
    logic  beat_fire;

    assign head_crossing = is_crossing(head.size_code, head_off);
    assign mem_valid     = !empty || (state == BEAT1);
    assign beat_fire     = mem_valid && mem_ready;
    assign pop           = beat_fire && ((state == BEAT1) || !head_crossing);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BEAT0;
        end else if (beat_fire) begin
            state <= (state == BEAT0 && head_crossing) ? BEAT1 : BEAT0;
        end
    end
`else
    logic unused_upper;

    assign mem_valid    = !empty;
    assign pop          = mem_valid && mem_ready;
    assign unused_upper = ^{head_mask[2*WB-1:WB], head_shifted[2*DATA_W-1:DATA_W]};
`endif

    always_comb begin
        // NOTE: every output is defaulted first, so no latch is inferred and idle outputs read as zero.
        mem_addr = '0;
        mem_din  = '0;
        mem_wea  = '0;
        mem_dst  = '0;
        if (mem_valid) begin
            mem_addr = head_base;
            mem_din  = head_shifted[DATA_W-1:0];
            mem_wea  = head_mask[WB-1:0];
            mem_dst  = head.dst;
`ifdef STORE_SPLIT_EN
            if (state == BEAT1) begin
                mem_addr = head_base + ADDR_W'(WB);
                mem_din  = head_shifted[2*DATA_W-1:DATA_W];
                mem_wea  = head_mask[2*WB-1:WB];
            end
`endif
        end
    end

    // NOTE: queue storage is not reset; the pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            queue[wr_ptr] <= '{size_code: st_funct3[1:0], addr: st_addr, data: st_data, dst: st_dst};
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= st_fire && !st_ok;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit (DATA_W=32, DEPTH=4); covers the split path when STORE_SPLIT_EN is defined.
module tb_store_align_unit;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   st_valid;
    logic                   st_ready;
    logic [2:0]             st_funct3;
    logic [ADDR_W-1:0]      st_addr;
    logic [DATA_W-1:0]      st_data;
    logic [1:0]             st_dst;
    logic                   mem_valid;
    logic                   mem_ready;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_din;
    logic [DATA_W/8-1:0]    mem_wea;
    logic [1:0]             mem_dst;
    logic                   misalign_err;
    logic [$clog2(DEPTH):0] pending;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    store_align_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_funct3    (st_funct3),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .st_dst       (st_dst),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_wea      (mem_wea),
        .mem_dst      (mem_dst),
        .misalign_err (misalign_err),
        .pending      (pending)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic [31:0] a, input logic [3:0] wea,
                              input logic [31:0] din, input logic [1:0] dst);
        check({tag, ".valid"}, 64'(mem_valid), 64'd1);
        check({tag, ".addr"},  64'(mem_addr),  64'(a));
        check({tag, ".wea"},   64'(mem_wea),   64'(wea));
        check({tag, ".din"},   64'(mem_din),   64'(din));
        check({tag, ".dst"},   64'(mem_dst),   64'(dst));
    endtask

    task automatic check_idle(input string tag, input logic [2:0] exp_pending);
        check({tag, ".valid"},   64'(mem_valid), 64'd0);
        check({tag, ".wea"},     64'(mem_wea),   64'd0);
        check({tag, ".pending"}, 64'(pending),   64'(exp_pending));
    endtask

    // Drive one request for a single edge; returns at the negedge after that edge.
    task automatic push(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d, input logic [1:0] dst);
        st_valid  = 1'b1;
        st_funct3 = f3;
        st_addr   = a;
        st_data   = d;
        st_dst    = dst;
        @(negedge clk);
        st_valid  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        st_valid  = 1'b0;
        st_funct3 = 3'b000;
        st_addr   = '0;
        st_data   = '0;
        st_dst    = 2'b00;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);

        check("reset.valid",    64'(mem_valid),    64'd0);
        check("reset.wea",      64'(mem_wea),      64'd0);
        check("reset.din",      64'(mem_din),      64'd0);
        check("reset.addr",     64'(mem_addr),     64'd0);
        check("reset.dst",      64'(mem_dst),      64'd0);
        check("reset.err",      64'(misalign_err), 64'd0);
        check("reset.pending",  64'(pending),      64'd0);
        check("reset.st_ready", 64'(st_ready),     64'd1);
        rst = 1'b0;

        // SB into empty queue: no combinational path, then one beat on lane 3.
        mem_ready = 1'b1;
        st_valid  = 1'b1;
        st_funct3 = 3'b000;
        st_addr   = 32'h0000_1003;
        st_data   = 32'h0000_00AB;
        st_dst    = 2'b01;
        #1 check("sb.no_comb_path", 64'(mem_valid), 64'd0);
        @(negedge clk);
        st_valid = 1'b0;
        check_beat("sb", 32'h0000_1000, 4'b1000, 32'hAB00_0000, 2'b01);
        check("sb.pending", 64'(pending), 64'd1);
        @(negedge clk);
        check_idle("sb.after", 3'd0);

        // Aligned SH on upper half, aligned SW.
        push(3'b001, 32'h0000_3002, 32'h0000_BEEF, 2'b10);
        check_beat("sh_hi", 32'h0000_3000, 4'b1100, 32'hBEEF_0000, 2'b10);
        @(negedge clk);
        push(3'b010, 32'h0000_4004, 32'h1122_3344, 2'b11);
        check_beat("sw", 32'h0000_4004, 4'b1111, 32'h1122_3344, 2'b11);
        @(negedge clk);
        check_idle("sw.after", 3'd0);

`ifdef STORE_SPLIT_EN
        push(3'b010, 32'h0000_2002, 32'h1122_3344, 2'b01);
        check_beat("split.b0", 32'h0000_2000, 4'b1100, 32'h3344_0000, 2'b01);
        check("split.b0.pending", 64'(pending), 64'd1);
        check("split.b0.err", 64'(misalign_err), 64'd0);
        @(negedge clk);
        check_beat("split.b1", 32'h0000_2004, 4'b0011, 32'h0000_1122, 2'b01);
        check("split.b1.pending", 64'(pending), 64'd1);
        @(negedge clk);
        check_idle("split.after", 3'd0);

        push(3'b001, 32'h0000_3001, 32'h0000_BEEF, 2'b01);
        check_beat("sh_mis", 32'h0000_3000, 4'b0110, 32'h00BE_EF00, 2'b01);
        @(negedge clk);
        check_idle("sh_mis.after", 3'd0);
`else
        push(3'b010, 32'h0000_2002, 32'h1122_3344, 2'b01);
        check("drop_sw.err", 64'(misalign_err), 64'd1);
        check_idle("drop_sw", 3'd0);
        @(negedge clk);
        check("drop_sw.err_pulse", 64'(misalign_err), 64'd0);
        check_idle("drop_sw.after", 3'd0);

        push(3'b001, 32'h0000_3001, 32'h0000_BEEF, 2'b01);
        check("drop_sh.err", 64'(misalign_err), 64'd1);
        check_idle("drop_sh", 3'd0);
        @(negedge clk);
        check("drop_sh.err_pulse", 64'(misalign_err), 64'd0);
`endif

        // Illegal funct3 values are dropped in every build.
        push(3'b100, 32'h0000_5000, 32'h0000_0001, 2'b01);
        check("illegal.err", 64'(misalign_err), 64'd1);
        check_idle("illegal", 3'd0);
        @(negedge clk);
        check("illegal.err_pulse", 64'(misalign_err), 64'd0);
        push(3'b011, 32'h0000_5000, 32'h0000_0001, 2'b01);
        check("sd32.err", 64'(misalign_err), 64'd1);
        check_idle("sd32", 3'd0);
        @(negedge clk);

        // Back-pressure: fill the queue, hold a fifth request, then drain in order.
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            st_valid  = 1'b1;
            st_funct3 = 3'b010;
            st_addr   = 32'(i * 4);
            st_data   = 32'hC0DE_0000 | 32'(i);
            st_dst    = 2'b01;
            #1 check("fill.st_ready", 64'(st_ready), 64'd1);
            @(negedge clk);
        end
        st_addr = 32'h0000_0010;
        st_data = 32'hC0DE_0004;
        st_dst  = 2'b10;
        check("full.st_ready", 64'(st_ready), 64'd0);
        check("full.pending",  64'(pending),  64'd4);
        check_beat("full.head", 32'h0, 4'b1111, 32'hC0DE_0000, 2'b01);
        @(negedge clk);
        check("stall.pending", 64'(pending), 64'd4);
        check_beat("stall.head", 32'h0, 4'b1111, 32'hC0DE_0000, 2'b01);
        mem_ready = 1'b1;
        @(negedge clk);
        check_beat("drain1", 32'h4, 4'b1111, 32'hC0DE_0001, 2'b01);
        check("drain1.pending",  64'(pending),  64'd3);
        check("drain1.st_ready", 64'(st_ready), 64'd1);
        @(negedge clk);
        st_valid = 1'b0;
        check_beat("drain2", 32'h8, 4'b1111, 32'hC0DE_0002, 2'b01);
        check("drain2.pending", 64'(pending), 64'd3);
        @(negedge clk);
        check_beat("drain3", 32'hC, 4'b1111, 32'hC0DE_0003, 2'b01);
        check("drain3.pending", 64'(pending), 64'd2);
        @(negedge clk);
        check_beat("drain4", 32'h10, 4'b1111, 32'hC0DE_0004, 2'b10);
        check("drain4.pending", 64'(pending), 64'd1);
        @(negedge clk);
        check_idle("drain.after", 3'd0);

        // Reset with queued entries discards them.
        mem_ready = 1'b0;
        push(3'b000, 32'h0000_6000, 32'h0000_0012, 2'b01);
        push(3'b000, 32'h0000_6001, 32'h0000_0034, 2'b01);
        check("rstq.pending", 64'(pending), 64'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("rstq", 3'd0);
        check("rstq.st_ready", 64'(st_ready), 64'd1);

`ifdef STORE_SPLIT_EN
        // Reset while the split store sits in BEAT1.
        mem_ready = 1'b1;
        push(3'b010, 32'h0000_2002, 32'h1122_3344, 2'b01);
        check("rst_b1.b0.addr", 64'(mem_addr), 64'h2000);
        @(negedge clk);
        check("rst_b1.b1.addr", 64'(mem_addr), 64'h2004);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("rst_b1", 3'd0);
`endif

        mem_ready = 1'b1;
        push(3'b000, 32'h0000_1001, 32'h0000_005A, 2'b01);
        check_beat("post_rst_sb", 32'h0000_1000, 4'b0010, 32'h0000_5A00, 2'b01);
        @(negedge clk);
        check_idle("post_rst.after", 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
